// File: rtl/ula_pkg.sv
// Shared definitions for the ULA sharing arbiter.
// Opcode/funct encodings, FSM states and the latency decode helper.
package ula_pkg;

    localparam logic [5:0] OP_ARIT  = 6'b000000;
    localparam logic [5:0] OP_LOGIC = 6'b000001;
    localparam logic [5:0] OP_BEQ   = 6'b001010;

    localparam logic [5:0] FN_ADD  = 6'b000000;
    localparam logic [5:0] FN_SUB  = 6'b000001;
    localparam logic [5:0] FN_MULT = 6'b000010;
    localparam logic [5:0] FN_DIV  = 6'b000011;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // MULT and DIV need the long hold window on the ULA inputs.
    function automatic logic is_long_op(input logic [5:0] opcode,
                                        input logic [5:0] funct);
        return (opcode == OP_ARIT) &&
               ((funct == FN_MULT) || (funct == FN_DIV));
    endfunction

endpackage

// File: rtl/ula_rr_arbiter.sv
// Two-way round-robin grant with a last_grant pointer.
// On a tie the requester that did not win last time is granted.
module ula_rr_arbiter (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic enable,
    input  logic advance,
    output logic gnt0,
    output logic gnt1,
    output logic owner
);

    logic last_grant;

    // Grant the lone requester, or the one not served last on a tie.
    always_comb begin
        gnt0  = enable && req0 && (!req1 || last_grant);
        gnt1  = enable && req1 && (!req0 || !last_grant);
        owner = gnt1;
    end

    // Pointer starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= owner;
        end
    end

endmodule

// File: rtl/ula_arbiter.sv
// Shares the combinational ULA between the CPU execute stage and the
// context-swap unit; holds operands for a per-op window, returns result.
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int SHORT_LAT = 1,
    parameter int LONG_LAT  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [5:0]        req0_opcode,
    input  logic [5:0]        req0_funct,
    input  logic [DATA_W-1:0] req0_dados_1,
    input  logic [DATA_W-1:0] req0_dados_2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [5:0]        req1_opcode,
    input  logic [5:0]        req1_funct,
    input  logic [DATA_W-1:0] req1_dados_1,
    input  logic [DATA_W-1:0] req1_dados_2,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_resultado,
    output logic              rsp_zero,
    output logic              busy,
    output logic [5:0]        alu_opcode,
    output logic [5:0]        alu_funct,
    output logic [DATA_W-1:0] alu_dados_1,
    output logic [DATA_W-1:0] alu_dados_2,
    input  logic [DATA_W-1:0] alu_resultado,
    input  logic              alu_zero
);

    localparam int CNT_W = $clog2(LONG_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(LONG_LAT);
    localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(SHORT_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              owner_q;
    logic              idle;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_owner;
    logic              accept;
    logic              done;
    logic [5:0]        sel_opcode;
    logic [5:0]        sel_funct;
    logic [DATA_W-1:0] sel_dados_1;
    logic [DATA_W-1:0] sel_dados_2;

    assign idle       = (state == IDLE);
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    ula_rr_arbiter u_rr (
        .clock   (clock),
        .reset   (reset),
        .req0    (req0_valid),
        .req1    (req1_valid),
        .enable  (idle),
        .advance (accept),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .owner   (gnt_owner)
    );

    // Route the granted requester's fields toward the operand registers.
    always_comb begin
        sel_opcode  = req0_opcode;
        sel_funct   = req0_funct;
        sel_dados_1 = req0_dados_1;
        sel_dados_2 = req0_dados_2;
        if (gnt1) begin
            sel_opcode  = req1_opcode;
            sel_funct   = req1_funct;
            sel_dados_1 = req1_dados_1;
            sel_dados_2 = req1_dados_2;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: accept a grant in IDLE, leave EXEC on the last count.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                busy = 1'b1;
                if (cnt == CNT_ONE) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand hold, window counter and result capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_opcode    <= '0;
            alu_funct     <= '0;
            alu_dados_1   <= '0;
            alu_dados_2   <= '0;
            owner_q       <= 1'b0;
            cnt           <= '0;
            rsp_resultado <= '0;
            rsp_zero      <= 1'b0;
            rsp0_valid    <= 1'b0;
            rsp1_valid    <= 1'b0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (accept) begin
                alu_opcode  <= sel_opcode;
                alu_funct   <= sel_funct;
                alu_dados_1 <= sel_dados_1;
                alu_dados_2 <= sel_dados_2;
                owner_q     <= gnt_owner;
                cnt         <= is_long_op(sel_opcode, sel_funct) ?
                               CNT_LONG : CNT_SHORT;
            end else if (busy) begin
                cnt <= cnt - CNT_ONE;
            end
            if (done) begin
                rsp_resultado <= alu_resultado;
                rsp_zero      <= alu_zero;
                rsp0_valid    <= !owner_q;
                rsp1_valid    <= owner_q;
            end
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter with a small behavioural ULA
// attached to the alu_* ports.
module tb_ula_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [5:0]  req0_opcode, req0_funct;
    logic [31:0] req0_dados_1, req0_dados_2;
    logic        req1_valid, req1_ready;
    logic [5:0]  req1_opcode, req1_funct;
    logic [31:0] req1_dados_1, req1_dados_2;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_resultado;
    logic        rsp_zero;
    logic        busy;
    logic [5:0]  alu_opcode, alu_funct;
    logic [31:0] alu_dados_1, alu_dados_2;
    logic [31:0] alu_resultado;
    logic        alu_zero;

    int n_checks = 0;
    int n_fail   = 0;

    ula_arbiter #(.DATA_W(32), .SHORT_LAT(1), .LONG_LAT(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_opcode   (req0_opcode),
        .req0_funct    (req0_funct),
        .req0_dados_1  (req0_dados_1),
        .req0_dados_2  (req0_dados_2),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_opcode   (req1_opcode),
        .req1_funct    (req1_funct),
        .req1_dados_1  (req1_dados_1),
        .req1_dados_2  (req1_dados_2),
        .rsp0_valid    (rsp0_valid),
        .rsp1_valid    (rsp1_valid),
        .rsp_resultado (rsp_resultado),
        .rsp_zero      (rsp_zero),
        .busy          (busy),
        .alu_opcode    (alu_opcode),
        .alu_funct     (alu_funct),
        .alu_dados_1   (alu_dados_1),
        .alu_dados_2   (alu_dados_2),
        .alu_resultado (alu_resultado),
        .alu_zero      (alu_zero)
    );

    always #5 clock = ~clock;

    // Behavioural ULA: ARIT add/sub/mult/div, BEQ, others return 0.
    always_comb begin
        alu_resultado = 32'd0;
        alu_zero      = 1'b0;
        case (alu_opcode)
            6'd0: begin
                case (alu_funct)
                    6'd0: alu_resultado = alu_dados_1 + alu_dados_2;
                    6'd1: alu_resultado = alu_dados_1 - alu_dados_2;
                    6'd2: alu_resultado = alu_dados_1 * alu_dados_2;
                    6'd3: alu_resultado = (alu_dados_2 == 0) ? 32'd0 :
                                          alu_dados_1 / alu_dados_2;
                    default: alu_resultado = 32'd0;
                endcase
                alu_zero = (alu_resultado == 32'd0);
            end
            6'd10: begin
                alu_resultado = alu_dados_1 - alu_dados_2;
                alu_zero      = (alu_dados_1 == alu_dados_2);
            end
            default: begin
                alu_resultado = 32'd0;
                alu_zero      = 1'b0;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b);
        req0_valid   = 1'b1;
        req0_opcode  = op;
        req0_funct   = fn;
        req0_dados_1 = a;
        req0_dados_2 = b;
    endtask

    task automatic drive1(input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b);
        req1_valid   = 1'b1;
        req1_opcode  = op;
        req1_funct   = fn;
        req1_dados_1 = a;
        req1_dados_2 = b;
    endtask

    // Requester rule: a pending request must not change until ready.
    logic [76:0] prev0, prev1;
    logic        pend0 = 1'b0;
    logic        pend1 = 1'b0;
    always @(negedge clock) begin
        if (pend0)
            check("hold0", {31'd0, prev0 !== {req0_valid, req0_opcode,
                  req0_funct, req0_dados_1, req0_dados_2}}, 32'd0);
        if (pend1)
            check("hold1", {31'd0, prev1 !== {req1_valid, req1_opcode,
                  req1_funct, req1_dados_1, req1_dados_2}}, 32'd0);
        pend0 = req0_valid && !req0_ready && !reset;
        pend1 = req1_valid && !req1_ready && !reset;
        prev0 = {req0_valid, req0_opcode, req0_funct,
                 req0_dados_1, req0_dados_2};
        prev1 = {req1_valid, req1_opcode, req1_funct,
                 req1_dados_1, req1_dados_2};
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e;
        reset = 1'b1;
        req0_valid = 0; req0_opcode = 0; req0_funct = 0;
        req0_dados_1 = 0; req0_dados_2 = 0;
        req1_valid = 0; req1_opcode = 0; req1_funct = 0;
        req1_dados_1 = 0; req1_dados_2 = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_alu_d1", alu_dados_1, 32'd0);
        check("rst_alu_op", {26'd0, alu_opcode}, 32'd0);
        check("rst_res", rsp_resultado, 32'd0);
        check("rst_rsp0", {31'd0, rsp0_valid}, 32'd0);
        check("rst_rsp1", {31'd0, rsp1_valid}, 32'd0);
        reset = 1'b0;
        cyc();

        // Both requesters continuously valid: grants 0,1,0,1 then 0.
        drive0(6'd10, 6'd0, 32'd3, 32'd3);
        drive1(6'd0, 6'd1, 32'd10, 32'd4);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = k % 2;
            check("rr_rdy0", {31'd0, req0_ready}, (e == 0) ? 32'd1 : 32'd0);
            check("rr_rdy1", {31'd0, req1_ready}, (e == 1) ? 32'd1 : 32'd0);
            cyc();
            if (k == 3) req1_valid = 1'b0;
            check("rr_busy", {31'd0, busy}, 32'd1);
            check("rr_no_rdy", {31'd0, req0_ready | req1_ready}, 32'd0);
            cyc();
            check("rr_rsp0", {31'd0, rsp0_valid}, (e == 0) ? 32'd1 : 32'd0);
            check("rr_rsp1", {31'd0, rsp1_valid}, (e == 1) ? 32'd1 : 32'd0);
            check("rr_res", rsp_resultado, (e == 1) ? 32'd6 : 32'd0);
            check("rr_zero", {31'd0, rsp_zero}, (e == 1) ? 32'd0 : 32'd1);
        end
        check("rr_rdy0_last", {31'd0, req0_ready}, 32'd1);
        cyc();
        req0_valid = 1'b0;
        check("rr_busy_last", {31'd0, busy}, 32'd1);
        cyc();
        check("rr_rsp0_last", {31'd0, rsp0_valid}, 32'd1);
        check("rr_zero_last", {31'd0, rsp_zero}, 32'd1);
        cyc();

        // Single ADD on req0: 5 + 7.
        drive0(6'd0, 6'd0, 32'd5, 32'd7);
        #1;
        check("add_rdy0", {31'd0, req0_ready}, 32'd1);
        check("add_rdy1", {31'd0, req1_ready}, 32'd0);
        cyc();
        req0_valid = 1'b0;
        check("add_busy", {31'd0, busy}, 32'd1);
        check("add_d1", alu_dados_1, 32'd5);
        check("add_d2", alu_dados_2, 32'd7);
        check("add_rsp_early", {31'd0, rsp0_valid}, 32'd0);
        cyc();
        check("add_rsp0", {31'd0, rsp0_valid}, 32'd1);
        check("add_res", rsp_resultado, 32'd12);
        check("add_zero", {31'd0, rsp_zero}, 32'd0);
        check("add_idle", {31'd0, busy}, 32'd0);
        cyc();
        check("add_rsp0_low", {31'd0, rsp0_valid}, 32'd0);
        check("add_res_hold", rsp_resultado, 32'd12);

        // Undefined opcode on req1: short window, result 0, zero 0.
        drive1(6'b111111, 6'd0, 32'd1, 32'd2);
        #1;
        check("und_rdy1", {31'd0, req1_ready}, 32'd1);
        cyc();
        req1_valid = 1'b0;
        check("und_op", {26'd0, alu_opcode}, 32'd63);
        check("und_busy", {31'd0, busy}, 32'd1);
        cyc();
        check("und_rsp1", {31'd0, rsp1_valid}, 32'd1);
        check("und_res", rsp_resultado, 32'd0);
        check("und_zero", {31'd0, rsp_zero}, 32'd0);
        cyc();

        // Back-to-back on req0: second op accepted in the response cycle.
        drive0(6'd0, 6'd0, 32'd20, 32'd22);
        #1;
        check("b2b_rdy_a", {31'd0, req0_ready}, 32'd1);
        cyc();
        drive0(6'd0, 6'd1, 32'd9, 32'd9);
        #1;
        check("b2b_rdy_exec", {31'd0, req0_ready}, 32'd0);
        cyc();
        check("b2b_rsp_a", {31'd0, rsp0_valid}, 32'd1);
        check("b2b_res_a", rsp_resultado, 32'd42);
        check("b2b_rdy_b", {31'd0, req0_ready}, 32'd1);
        cyc();
        req0_valid = 1'b0;
        check("b2b_busy_b", {31'd0, busy}, 32'd1);
        check("b2b_d1_b", alu_dados_1, 32'd9);
        cyc();
        check("b2b_rsp_b", {31'd0, rsp0_valid}, 32'd1);
        check("b2b_res_b", rsp_resultado, 32'd0);
        check("b2b_zero_b", {31'd0, rsp_zero}, 32'd1);
        cyc();

        // MULT on req1 (long window); req0 waits with an ADD.
        drive1(6'd0, 6'd2, 32'd6, 32'd9);
        #1;
        check("mul_rdy1", {31'd0, req1_ready}, 32'd1);
        cyc();
        req1_valid = 1'b0;
        drive0(6'd0, 6'd0, 32'd1, 32'd1);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("mul_busy", {31'd0, busy}, 32'd1);
            check("mul_rdy0_blk", {31'd0, req0_ready}, 32'd0);
            check("mul_rsp_early", {31'd0, rsp1_valid}, 32'd0);
            cyc();
        end
        check("mul_rsp1", {31'd0, rsp1_valid}, 32'd1);
        check("mul_res", rsp_resultado, 32'd54);
        check("mul_idle", {31'd0, busy}, 32'd0);
        check("mul_rdy0", {31'd0, req0_ready}, 32'd1);
        cyc();
        req0_valid = 1'b0;
        check("mul_add_busy", {31'd0, busy}, 32'd1);
        cyc();
        check("mul_add_rsp0", {31'd0, rsp0_valid}, 32'd1);
        check("mul_add_res", rsp_resultado, 32'd2);
        cyc();

        // DIV on req0 aborted by a mid-cycle reset.
        drive0(6'd0, 6'd3, 32'd100, 32'd5);
        #1;
        check("div_rdy0", {31'd0, req0_ready}, 32'd1);
        cyc();
        req0_valid = 1'b0;
        check("div_busy", {31'd0, busy}, 32'd1);
        check("div_d1", alu_dados_1, 32'd100);
        check("div_fn", {26'd0, alu_funct}, 32'd3);
        cyc();
        #2;
        reset = 1'b1;
        #1;
        check("arst_d1", alu_dados_1, 32'd0);
        check("arst_fn", {26'd0, alu_funct}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_res", rsp_resultado, 32'd0);
        check("arst_rsp0", {31'd0, rsp0_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("arst_no_rsp", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
        end
        reset = 1'b0;
        drive0(6'd0, 6'd0, 32'd3, 32'd4);
        drive1(6'd0, 6'd1, 32'd9, 32'd2);
        #1;
        check("post_rdy0", {31'd0, req0_ready}, 32'd1);
        check("post_rdy1", {31'd0, req1_ready}, 32'd0);
        cyc();
        req0_valid = 1'b0;
        check("post_busy", {31'd0, busy}, 32'd1);
        cyc();
        check("post_rsp0", {31'd0, rsp0_valid}, 32'd1);
        check("post_res0", rsp_resultado, 32'd7);
        check("post_rdy1b", {31'd0, req1_ready}, 32'd1);
        cyc();
        req1_valid = 1'b0;
        cyc();
        check("post_rsp1", {31'd0, rsp1_valid}, 32'd1);
        check("post_res1", rsp_resultado, 32'd7);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
- Shares the single combinational ULA between two requesters: port 0 is the CPU execute stage, port 1 is the kernel/context-swap unit.
- Arbitrates round-robin and registers the winning operands so the ULA inputs stay stable.
- Holds those inputs for a multicycle window sized per operation: long for MULT/DIV, short otherwise.
- Captures Resultado/Zero and returns them to the owning requester with a one-cycle response pulse.

Parameters:
- DATA_W, 32, operand/result width; fixed at 32 for the current ULA.
- SHORT_LAT, 1, EXEC cycles for all non-MULT/DIV operations (>=1).
- LONG_LAT, 4, EXEC cycles for MULT/DIV (>=SHORT_LAT); counter width is $clog2(LONG_LAT+1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_opcode  in  6  ULA Opcode.
- req0_funct  in  6  ULA funct.
- req0_dados_1  in  DATA_W  operand 1.
- req0_dados_2  in  DATA_W  operand 2.
- req1_valid, req1_ready, req1_opcode, req1_funct, req1_dados_1, req1_dados_2: same as the req0 ports, for requester 1.
- rsp0_valid  out  1  one-cycle pulse: result for requester 0.
- rsp1_valid  out  1  one-cycle pulse: result for requester 1.
- rsp_resultado  out  DATA_W  captured Resultado.
- rsp_zero  out  1  captured Zero.
- busy  out  1  high in EXEC.
- alu_opcode  out  6  to ULA Opcode.
- alu_funct  out  6  to ULA funct.
- alu_dados_1  out  DATA_W  to ULA Dados_1.
- alu_dados_2  out  DATA_W  to ULA Dados_2.
- alu_resultado  in  DATA_W  from ULA Resultado.
- alu_zero  in  1  from ULA Zero.

Behaviour:
- Reset (async, active-high) puts the FSM in IDLE.
  - All output registers go to 0: alu_*, rsp_*, rspN_valid.
  - Round-robin pointer last_grant=1, so req0 wins the first tie.
- FSM states: IDLE, EXEC.
- IDLE:
  - grant = the single valid requester; if both are valid, the requester that is not last_grant.
  - reqN_ready = (state==IDLE) && grant==N. This is combinational; only one ready is ever high.
  - Handshake on valid&ready in cycle t:
    - latch opcode/funct/dados into the alu_* registers;
    - record owner and set last_grant=owner;
    - load cnt = LONG_LAT if opcode==6'b000000 and funct in {6'b000010, 6'b000011}, else SHORT_LAT;
    - next state EXEC.
  - No valid: stay in IDLE; alu_* hold their last values.
- EXEC (cycles t+1 .. t+L):
  - alu_* stable and busy=1.
  - cnt decrements each cycle.
  - In the cycle cnt==1: capture alu_resultado/alu_zero into rsp_resultado/rsp_zero, and set rsp<owner>_valid=1 for the next cycle; next state IDLE.
- Response:
  - rspN_valid is high exactly in cycle t+L+1, then low.
  - rsp_resultado/rsp_zero hold until the next capture.
- Latency: handshake to response is L+1 cycles.
  - A new handshake may occur in cycle t+L+1, the same cycle as the response.
  - Peak throughput is one op per L+1 cycles.
- Requester rule: valid and all request fields must be held until ready. The bench asserts this; the design does not check it.
- Undefined opcodes are passed through with SHORT_LAT. The ULA returns 0, and that value is returned.
- Both requesters continuously valid: grants alternate 0,1,0,1.
- Reset mid-EXEC: the operation is aborted, no rspN_valid is produced, and the pointer returns to last_grant=1.
- Width: no arithmetic in this block. The only decode is the MULT/DIV check, on exact 6-bit compares.

Decomposition:
- Shared package ula_pkg holds:
  - opcode constants: OP_ARIT=6'b000000, OP_LOGIC=6'b000001, etc.;
  - funct constants: FN_MULT=6'b000010, FN_DIV=6'b000011;
  - state typedef {IDLE, EXEC}.
- The ULA itself stays external.
- One natural sub-module: ula_rr_arbiter, a 2-way round-robin grant with last_grant register.

Test Plan:
- Single ADD on req0: opcode 0, funct 0, 5 and 7, handshake at t -> req0_ready=1 at t; alu_dados stable t+1; rsp0_valid=1 only at t+2 with rsp_resultado=12, rsp_zero=0.
- MULT on req1 with LONG_LAT=4: opcode 0, funct 2, 6 and 9 -> busy t+1..t+4; rsp1_valid at t+5, resultado=54; req0 asserting valid during EXEC sees ready=0 throughout.
- Both requesters valid continuously with BEQ (opcode 10, 3, 3) on req0 and SUB (opcode 0, funct 1, 10, 4) on req1 -> grants 0,1,0,1; req0 responses rsp_zero=1, resultado=0; req1 responses resultado=6.
- Back-to-back: a second req0 op presented in the response cycle -> accepted that same cycle; no idle gap beyond L+1 cycles per op.
- Reset asserted during DIV EXEC (100/5): reset high asynchronously mid-cycle -> outputs 0 immediately, no rsp pulse; after release, both valid -> req0 granted first.
- Undefined opcode 6'b111111 -> SHORT_LAT path; rsp returns resultado=0, zero=0.
